// File: rtl/slave_bus_pkg.sv
// Shared types and constants for the Extended_DLX bus-slave card.
// Imported by the sequencer and its interface.
package slave_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  localparam int AI_IDX_LSB = 0;
  localparam int AI_IDX_W   = 5;
  localparam int AI_MON_LSB = 5;
  localparam int AI_MON_W   = 2;
  localparam int AI_LAT_W   = 7;

  localparam logic [AI_LAT_W-1:0] CFG_ADDR = 7'h7F;

  localparam logic [AI_MON_W-1:0] MON_A = 2'b00;
  localparam logic [AI_MON_W-1:0] MON_B = 2'b01;
  localparam logic [AI_MON_W-1:0] MON_C = 2'b10;
  localparam logic [AI_MON_W-1:0] MON_D = 2'b11;

  function automatic logic is_cfg(
    input logic [AI_LAT_W-1:0] ai,
    input logic                wr_n
  );
    return (ai == CFG_ADDR) && !wr_n;
  endfunction

endpackage

// File: rtl/slave_bus_ctrl_if.sv
// Bus-pin bundle between the backplane master and the slave sequencer.
// The master side drives the cycle, the slave side answers it.
interface slave_bus_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int AI_W   = 10
);

  logic              CARDSEL;
  logic              WR_N;
  logic [AI_W-1:0]   AI;
  logic [DATA_W-1:0] DI;

  logic              SACK_N;
  logic [1:0]        MUX_SEL;
  logic              OUT_EN;
  logic              REG_WE;
  logic [4:0]        REG_ADDR;
  logic              BUSY;
  logic              ERR;

  modport master (
    output CARDSEL,
    output WR_N,
    output AI,
    output DI,
    input  SACK_N,
    input  MUX_SEL,
    input  OUT_EN,
    input  REG_WE,
    input  REG_ADDR,
    input  BUSY,
    input  ERR
  );

  modport slave (
    input  CARDSEL,
    input  WR_N,
    input  AI,
    input  DI,
    output SACK_N,
    output MUX_SEL,
    output OUT_EN,
    output REG_WE,
    output REG_ADDR,
    output BUSY,
    output ERR
  );

endinterface

// File: rtl/slave_wait_cnt.sv
// Loadable saturating down-counter with zero/one flags.
// Used for wait states and for the post-ack timeout.
module slave_wait_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/slave_bus_ctrl.sv
// Bus-cycle sequencer for the Extended_DLX slave card: decode,
// wait states, one-cycle acknowledge, write strobe and timeout.
import slave_bus_pkg::*;

module slave_bus_ctrl #(
  parameter int DATA_W   = 32,
  parameter int AI_W     = 10,
  parameter int WAIT_W   = 3,
  parameter int DEF_WAIT = 1,
  parameter int TMO      = 15
) (
  input  logic            CLK,
  input  logic            RESET_N,
  slave_bus_ctrl_if.slave bus
);

  localparam int TMO_W = $clog2(TMO + 1);

  localparam logic [WAIT_W-1:0] DEF_CFG = WAIT_W'(DEF_WAIT);
  // Loaded one short so ERR rises TMO cycles after the ack cycle.
  localparam logic [TMO_W-1:0]  TMO_LD  = TMO_W'(TMO - 1);

  state_t state;
  state_t nxt;

  logic [WAIT_W-1:0]   wait_cfg;
  logic [AI_LAT_W-1:0] ai_q;
  logic [AI_LAT_W-1:0] ai_nxt;
  logic                wr_n_q;
  logic                wr_n_nxt;

  logic latch;
  logic cnt_ld;
  logic cnt_dec;
  logic cnt_zero;
  logic cnt_one;
  logic tmo_ld;
  logic tmo_dec;
  logic tmo_zero;
  logic tmo_one;
  logic cfg_ld;
  logic err_set;

  logic sack_n_q;
  logic oe_q;
  logic we_q;
  logic busy_q;
  logic err_q;

  logic oe_nxt;
  logic we_nxt;

  slave_wait_cnt #(
    .W (WAIT_W)
  ) u_wait (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (cnt_ld),
    .load_val (wait_cfg),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  slave_wait_cnt #(
    .W (TMO_W)
  ) u_tmo (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (tmo_ld),
    .load_val (TMO_LD),
    .dec      (tmo_dec),
    .zero     (tmo_zero),
    .one      (tmo_one)
  );

  always_comb begin
    nxt     = state;
    latch   = 1'b0;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    tmo_ld  = 1'b0;
    tmo_dec = 1'b0;
    cfg_ld  = 1'b0;
    err_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.CARDSEL) begin
          latch  = 1'b1;
          cnt_ld = 1'b1;
          nxt    = (wait_cfg == '0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.CARDSEL) begin
          nxt = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_one || cnt_zero) nxt = S_ACK;
        end
      end
      S_ACK: begin
        nxt    = S_REL;
        tmo_ld = 1'b1;
        cfg_ld = is_cfg(ai_q, wr_n_q);
      end
      S_REL: begin
        if (!bus.CARDSEL) begin
          nxt = S_IDLE;
        end else begin
          tmo_dec = 1'b1;
          err_set = tmo_one || tmo_zero;
        end
      end
    endcase
  end

  // Outputs are registered from next-state values, so they are glitch-free.
  always_comb begin
    ai_nxt   = latch ? bus.AI[AI_LAT_W-1:0] : ai_q;
    wr_n_nxt = latch ? bus.WR_N : wr_n_q;
    oe_nxt   = ((nxt == S_WAIT) || (nxt == S_ACK)) && wr_n_nxt;
    we_nxt   = (nxt == S_ACK) && !wr_n_nxt
               && !is_cfg(ai_nxt, wr_n_nxt);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      ai_q     <= '0;
      wr_n_q   <= 1'b1;
      wait_cfg <= DEF_CFG;
      sack_n_q <= 1'b1;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= nxt;
      ai_q     <= ai_nxt;
      wr_n_q   <= wr_n_nxt;
      if (cfg_ld) wait_cfg <= bus.DI[WAIT_W-1:0];
      sack_n_q <= (nxt != S_ACK);
      oe_q     <= oe_nxt;
      we_q     <= we_nxt;
      busy_q   <= (nxt != S_IDLE);
      err_q    <= (err_q || err_set) && bus.CARDSEL;
    end
  end

  assign bus.SACK_N   = sack_n_q;
  assign bus.OUT_EN   = oe_q;
  assign bus.REG_WE   = we_q;
  assign bus.BUSY     = busy_q;
  assign bus.ERR      = err_q;
  assign bus.MUX_SEL  = ai_q[AI_MON_LSB +: AI_MON_W];
  assign bus.REG_ADDR = ai_q[AI_IDX_LSB +: AI_IDX_W];

endmodule

// File: tb/tb_slave_bus_ctrl.sv
// Directed vector bench for slave_bus_ctrl: table of bus cycles
// plus hand sequences for abort, timeout and mid-cycle reset.
module tb_slave_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  slave_bus_ctrl_if #(.DATA_W(32), .AI_W(10)) bus ();

  slave_bus_ctrl #(
    .DATA_W   (32),
    .AI_W     (10),
    .WAIT_W   (3),
    .DEF_WAIT (1),
    .TMO      (15)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        wr;
    logic [9:0]  ai;
    logic [31:0] di;
    int          ack;
    int          we;
    int          mux;
    int          addr;
    int          oe;
  } vec_t;

  vec_t tbl [11];

  int total = 0;
  int bad   = 0;

  int ack_at, ack_cnt, we_cnt, we_bad, oe_cnt, err_at;
  int err_last, busy_after, err_after, mux_s, addr_s;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] outs();
    return {bus.SACK_N, bus.OUT_EN, bus.REG_WE, bus.BUSY,
            bus.ERR, bus.MUX_SEL, bus.REG_ADDR};
  endfunction

  task automatic run_bus(input logic wr, input logic [9:0] ai,
                         input logic [31:0] di, input int hold);
    ack_at = -1; ack_cnt = 0; we_cnt = 0; we_bad = 0;
    oe_cnt = 0; err_at = -1; err_last = 0;
    mux_s = -1; addr_s = -1;
    bus.CARDSEL = 1'b1;
    bus.WR_N = wr;
    bus.AI = ai;
    bus.DI = di;
    for (int k = 1; k <= hold; k++) begin
      tick();
      if (k == 1) begin
        bus.WR_N = ~wr;
        bus.AI = ~ai;
      end
      if (!bus.SACK_N) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = k;
        mux_s = int'(bus.MUX_SEL);
        addr_s = int'(bus.REG_ADDR);
      end
      if (bus.REG_WE) begin
        we_cnt++;
        if (bus.SACK_N) we_bad++;
      end
      if (bus.OUT_EN) oe_cnt++;
      if (bus.ERR && err_at < 0) err_at = k;
      err_last = int'(bus.ERR);
    end
    bus.CARDSEL = 1'b0;
    tick();
    busy_after = int'(bus.BUSY);
    err_after = int'(bus.ERR);
    bus.WR_N = 1'b1;
    bus.AI = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sack_seen, we_seen, busy2;

    tbl[0]  = '{1'b1, 10'h01F, 32'h0, 2, 0, 0, 'h1F, 2};
    tbl[1]  = '{1'b0, 10'h075, 32'h5, 2, 1, 3, 'h15, 0};
    tbl[2]  = '{1'b0, 10'h07F, 32'h0, 2, 0, 3, 'h1F, 0};
    tbl[3]  = '{1'b1, 10'h06A, 32'h0, 1, 0, 3, 'h0A, 1};
    tbl[4]  = '{1'b0, 10'h07F, 32'h3, 1, 0, 3, 'h1F, 0};
    tbl[5]  = '{1'b0, 10'h023, 32'h6, 4, 1, 1, 'h03, 0};
    tbl[6]  = '{1'b1, 10'h3C4, 32'h0, 4, 0, 2, 'h04, 4};
    tbl[7]  = '{1'b1, 10'h07F, 32'h2, 4, 0, 3, 'h1F, 4};
    tbl[8]  = '{1'b0, 10'h07F, 32'h7, 4, 0, 3, 'h1F, 0};
    tbl[9]  = '{1'b0, 10'h000, 32'h1, 8, 1, 0, 'h00, 0};
    tbl[10] = '{1'b0, 10'h07F, 32'h3, 8, 0, 3, 'h1F, 0};

    bus.CARDSEL = 1'b0;
    bus.WR_N = 1'b1;
    bus.AI = '0;
    bus.DI = '0;

    #12;
    chk("reset outs", 32'(outs()), 32'h800);
    #10 rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 11; i++) begin
      run_bus(tbl[i].wr, tbl[i].ai, tbl[i].di, 12);
      chk($sformatf("v%0d ack_at", i), ack_at, tbl[i].ack);
      chk($sformatf("v%0d ack_cnt", i), ack_cnt, 1);
      chk($sformatf("v%0d we_cnt", i), we_cnt, tbl[i].we);
      chk($sformatf("v%0d we_no_ack", i), we_bad, 0);
      chk($sformatf("v%0d oe_cnt", i), oe_cnt, tbl[i].oe);
      chk($sformatf("v%0d mux", i), mux_s, tbl[i].mux);
      chk($sformatf("v%0d addr", i), addr_s, tbl[i].addr);
      chk($sformatf("v%0d err", i), err_at, -1);
      chk($sformatf("v%0d busy_end", i), busy_after, 0);
    end

    // abort: wait_cfg is 3, CARDSEL drops after one WAIT cycle
    bus.CARDSEL = 1'b1;
    bus.WR_N = 1'b0;
    bus.AI = 10'h055;
    tick();
    chk("abort busy1", 32'(bus.BUSY), 1);
    bus.CARDSEL = 1'b0;
    sack_seen = 0;
    we_seen = 0;
    busy2 = -1;
    for (int k = 2; k <= 7; k++) begin
      tick();
      if (k == 2) busy2 = int'(bus.BUSY);
      if (!bus.SACK_N) sack_seen++;
      if (bus.REG_WE) we_seen++;
    end
    chk("abort busy2", busy2, 0);
    chk("abort sack", sack_seen, 0);
    chk("abort we", we_seen, 0);
    chk("abort mux", 32'(bus.MUX_SEL), 2);

    // timeout: ack in cycle 4, ERR from cycle 4+15
    run_bus(1'b1, 10'h011, 32'h0, 25);
    chk("tmo ack_at", ack_at, 4);
    chk("tmo ack_cnt", ack_cnt, 1);
    chk("tmo err_at", err_at, 19);
    chk("tmo err_sticky", err_last, 1);
    chk("tmo err_clear", err_after, 0);
    chk("tmo busy_clear", busy_after, 0);

    // reset while in WAIT, wait_cfg is 3
    bus.CARDSEL = 1'b1;
    bus.WR_N = 1'b1;
    bus.AI = 10'h075;
    tick();
    tick();
    chk("rstw pre oe", 32'(bus.OUT_EN), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw outs", 32'(outs()), 32'h800);
    bus.CARDSEL = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    run_bus(1'b1, 10'h001, 32'h0, 6);
    chk("rstw cfg ack_at", ack_at, 2);

    // reset while in ACK on a write, wait_cfg set to 2 first
    run_bus(1'b0, 10'h07F, 32'h2, 6);
    chk("cfg2 ack_at", ack_at, 2);
    bus.CARDSEL = 1'b1;
    bus.WR_N = 1'b0;
    bus.AI = 10'h075;
    tick();
    tick();
    tick();
    chk("rsta pre ack", 32'({bus.SACK_N, bus.REG_WE}), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rsta outs", 32'(outs()), 32'h800);
    bus.CARDSEL = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    run_bus(1'b1, 10'h001, 32'h0, 6);
    chk("rsta cfg ack_at", ack_at, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
